// File: rtl/exec_pkg.sv
// -----------------------------------------------------------------------------
// exec_pkg
// Shared types and constants for the execute stage.
//   op_t    : operation codes presented on exec_unit.op
//   state_t : exec_unit control states
//   FLAG_*  : bit positions inside the {N,Z,C,V} flags vector
// -----------------------------------------------------------------------------
package exec_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_ORR = 4'd3,
        OP_EOR = 4'd4,
        OP_MOV = 4'd5,
        OP_MUL = 4'd6
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/exec_mul_iter.sv
// -----------------------------------------------------------------------------
// exec_mul_iter
// Shift-add multiplier iteration state: accumulator, multiplicand, multiplier
// and iteration counter. One iteration is performed per cycle while step=1.
//
// Optional build macro: EXEC_EARLY_TERM_EN
//   When defined, 'last' also asserts on the iteration that shifts the
//   multiplier down to zero, so small multipliers finish early.
//
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   load         : capture mcand_in/mplr_in, clear acc and counter
//   step         : perform one shift-add iteration
//   mcand_in     : multiplicand (src1)
//   mplr_in      : multiplier (src2)
//   acc_nxt      : accumulator value after the current iteration
//   last         : current iteration is the final one
// -----------------------------------------------------------------------------
module exec_mul_iter
    import exec_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] mcand_in,
    input  logic [WIDTH-1:0] mplr_in,
    output logic [WIDTH-1:0] acc_nxt,
    output logic             last
);

    logic [WIDTH-1:0] acc_q,   acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplr_q,  mplr_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    // Accumulated value this iteration would produce; the FSM registers it
    // as the result on the final iteration.
    assign acc_nxt = mplr_q[0] ? (acc_q + mcand_q) : acc_q;

`ifdef EXEC_EARLY_TERM_EN
    // Stop once the shifted multiplier has no set bits left.
    assign last = (cnt_q == CNT_W'(WIDTH - 1)) || (mplr_q[WIDTH-1:1] == '0);
`else
    assign last = (cnt_q == CNT_W'(WIDTH - 1));
`endif

    always_comb begin
        acc_d   = acc_q;
        mcand_d = mcand_q;
        mplr_d  = mplr_q;
        cnt_d   = cnt_q;
        if (load) begin
            acc_d   = '0;
            mcand_d = mcand_in;
            mplr_d  = mplr_in;
            cnt_d   = '0;
        end else if (step) begin
            acc_d   = acc_nxt;
            mcand_d = mcand_q << 1;
            mplr_d  = mplr_q >> 1;
            cnt_d   = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q   <= '0;
            mcand_q <= '0;
            mplr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/exec_unit.sv
// -----------------------------------------------------------------------------
// exec_unit
// Execute stage: single-cycle ALU ops and a multi-cycle shift-add MUL behind a
// start/busy/done handshake. result and flags are registered and held until
// the next accepted operation completes.
//
// Optional build macro: EXEC_EARLY_TERM_EN (early MUL termination, see
// exec_mul_iter). Results are identical in both builds.
//
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   start    : request, accepted only in IDLE
//   op       : operation code (exec_pkg::op_t; 7-15 reserved -> result 0, flags 0)
//   src1     : operand 1 / multiplicand
//   src2     : operand 2 / multiplier
//   busy     : state is not IDLE
//   done     : one-cycle pulse when result/flags become valid
//   result   : registered result
//   flags    : registered {N,Z,C,V}
// -----------------------------------------------------------------------------
module exec_unit
    import exec_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flags_q,  flags_d;

    logic             mul_load;
    logic             mul_step;
    logic [WIDTH-1:0] mul_acc_nxt;
    logic             mul_last;

    logic [WIDTH-1:0] alu_res;
    logic [3:0]       alu_flags;

    // Pack {N,Z,C,V} from a result and the arithmetic carry/overflow bits.
    function automatic logic [3:0] pack_flags(input logic [WIDTH-1:0] res,
                                              input logic c, input logic v);
        logic [3:0] f;
        f         = '0;
        f[FLAG_N] = res[WIDTH-1];
        f[FLAG_Z] = (res == '0);
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

    exec_mul_iter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_mul_iter (
        .clk      (clk),
        .rst      (rst),
        .load     (mul_load),
        .step     (mul_step),
        .mcand_in (src1),
        .mplr_in  (src2),
        .acc_nxt  (mul_acc_nxt),
        .last     (mul_last)
    );

    // Single-cycle ALU, evaluated on the live operands at the accept edge.
    always_comb begin
        logic signed [WIDTH-1:0] sa;
        logic signed [WIDTH-1:0] sb;
        logic        [WIDTH:0]   wide;
        logic                    ovf;
        sa        = signed'(src1);
        sb        = signed'(src2);
        wide      = '0;
        ovf       = 1'b0;
        alu_res   = '0;
        alu_flags = '0;
        case (op)
            OP_ADD: begin
                wide      = {1'b0, src1} + {1'b0, src2};
                alu_res   = wide[WIDTH-1:0];
                ovf       = (sa[WIDTH-1] == sb[WIDTH-1]) && (alu_res[WIDTH-1] != sa[WIDTH-1]);
                alu_flags = pack_flags(alu_res, wide[WIDTH], ovf);
            end
            OP_SUB: begin
                // Top bit of the widened difference is the borrow; C is its inverse.
                wide      = {1'b0, src1} - {1'b0, src2};
                alu_res   = wide[WIDTH-1:0];
                ovf       = (sa[WIDTH-1] != sb[WIDTH-1]) && (alu_res[WIDTH-1] != sa[WIDTH-1]);
                alu_flags = pack_flags(alu_res, ~wide[WIDTH], ovf);
            end
            OP_AND: begin
                alu_res   = src1 & src2;
                alu_flags = pack_flags(alu_res, 1'b0, 1'b0);
            end
            OP_ORR: begin
                alu_res   = src1 | src2;
                alu_flags = pack_flags(alu_res, 1'b0, 1'b0);
            end
            OP_EOR: begin
                alu_res   = src1 ^ src2;
                alu_flags = pack_flags(alu_res, 1'b0, 1'b0);
            end
            OP_MOV: begin
                alu_res   = src2;
                alu_flags = pack_flags(alu_res, 1'b0, 1'b0);
            end
            default: begin
                // Reserved codes (and MUL, which never takes this path) give zeros.
                alu_res   = '0;
                alu_flags = '0;
            end
        endcase
    end

    // Next-state and datapath control.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        flags_d  = flags_q;
        mul_load = 1'b0;
        mul_step = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (op == OP_MUL) begin
                        mul_load = 1'b1;
                        state_d  = ST_MUL;
                    end else begin
                        result_d = alu_res;
                        flags_d  = alu_flags;
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_MUL: begin
                mul_step = 1'b1;
                if (mul_last) begin
                    result_d = mul_acc_nxt;
                    flags_d  = pack_flags(mul_acc_nxt, 1'b0, 1'b0);
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign busy   = (state_q != ST_IDLE);
    assign done   = (state_q == ST_DONE);
    assign result = result_q;
    assign flags  = flags_q;

endmodule

// File: tb/tb_exec_unit.sv
module tb_exec_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [3:0]   op;
    logic [W-1:0] src1;
    logic [W-1:0] src2;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic [3:0]   flags;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    exec_unit #(.WIDTH(W), .CNT_W(5)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .src1   (src1),
        .src2   (src2),
        .busy   (busy),
        .done   (done),
        .result (result),
        .flags  (flags)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one operation and check latency, pulse width, result and flags.
    // lat_def / lat_et: cycles from accept edge to the cycle in which done is
    // seen, for the default and early-termination builds.
    // hammer: keep start high with a different ADD request while busy.
    task automatic run_op(input string tag, input logic [3:0] o,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input int lat_def, input int lat_et,
                          input logic [W-1:0] exp_res, input logic [3:0] exp_flags,
                          input bit hammer);
        int lat;
        int exp_lat;
`ifdef EXEC_EARLY_TERM_EN
        exp_lat = lat_et;
`else
        exp_lat = lat_def;
`endif
        @(negedge clk);
        start = 1'b1; op = o; src1 = a; src2 = b;
        @(posedge clk);
        #1;
        if (hammer) begin
            op = 4'd0; src1 = 32'h0000_1234; src2 = 32'h0000_0005;
        end else begin
            start = 1'b0; src1 = ~a; src2 = ~b;
        end
        lat = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 1) chk({tag, "_busy"}, 32'(busy), 32'd1);
            if (done) begin
                lat = k;
                break;
            end
        end
        start = 1'b0;
        chk({tag, "_lat"},    32'(lat), 32'(exp_lat));
        chk({tag, "_result"}, result, exp_res);
        chk({tag, "_flags"},  32'(flags), 32'(exp_flags));
        @(negedge clk);
        chk({tag, "_pulse"},  32'({busy, done}), 32'd0);
        @(negedge clk);
        chk({tag, "_hold"},   result, exp_res);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 4'd0; src1 = '0; src2 = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy",   32'(busy),   32'd0);
        chk("rst_done",   32'(done),   32'd0);
        chk("rst_result", result,      32'd0);
        chk("rst_flags",  32'(flags),  32'd0);
        rst = 1'b0;

        // ALU ops: flags are {N,Z,C,V}
        run_op("add_ovf",  4'd0, 32'h7FFF_FFFF, 32'h0000_0001, 1, 1, 32'h8000_0000, 4'b1001, 1'b0);
        run_op("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'h0000_0001, 1, 1, 32'h0000_0000, 4'b0110, 1'b0);
        run_op("sub_eq",   4'd1, 32'd5,         32'd5,         1, 1, 32'h0000_0000, 4'b0110, 1'b0);
        run_op("sub_neg",  4'd1, 32'd3,         32'd5,         1, 1, 32'hFFFF_FFFE, 4'b1000, 1'b0);
        run_op("sub_ovf",  4'd1, 32'h8000_0000, 32'd1,         1, 1, 32'h7FFF_FFFF, 4'b0011, 1'b0);
        run_op("and",      4'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 1, 1, 32'hF000_F000, 4'b1000, 1'b0);
        run_op("orr",      4'd3, 32'h0000_000F, 32'h0000_00F0, 1, 1, 32'h0000_00FF, 4'b0000, 1'b0);
        run_op("eor",      4'd4, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1, 1, 32'h0000_0000, 4'b0100, 1'b0);
        run_op("mov",      4'd5, 32'h0000_0001, 32'h8000_0000, 1, 1, 32'h8000_0000, 4'b1000, 1'b0);
        run_op("rsvd",     4'd9, 32'hFFFF_FFFF, 32'h0000_0001, 1, 1, 32'h0000_0000, 4'b0000, 1'b0);

        // Reset in the middle of a MUL: outputs clear immediately.
        @(negedge clk);
        start = 1'b1; op = 4'd6; src1 = 32'd7; src2 = 32'd9;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_busy", 32'(busy), 32'd1);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst_busy",   32'(busy),  32'd0);
        chk("arst_done",   32'(done),  32'd0);
        chk("arst_result", result,     32'd0);
        chk("arst_flags",  32'(flags), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // MUL
        run_op("mul_7x9",   4'd6, 32'd7,         32'd9,         33, 5,  32'd63, 4'b0000, 1'b0);
        run_op("mul_trunc", 4'd6, 32'h0001_0000, 32'h0001_0000, 33, 18, 32'd0,  4'b0100, 1'b0);
        run_op("mul_busy",  4'd6, 32'd6,         32'd7,         33, 4,  32'd42, 4'b0000, 1'b1);
        run_op("add_after", 4'd0, 32'd1,         32'd2,         1,  1,  32'd3,  4'b0000, 1'b0);
        run_op("mul_12x5",  4'd6, 32'd12,        32'd5,         33, 4,  32'd60, 4'b0000, 1'b0);
        run_op("mul_9x0",   4'd6, 32'd9,         32'd0,         33, 2,  32'd0,  4'b0100, 1'b0);
        run_op("mul_neg",   4'd6, 32'hFFFF_FFFF, 32'd3,         33, 3,  32'hFFFF_FFFD, 4'b1000, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/exec_unit.md
Name: exec_unit

Overview:
- Execute stage directly downstream of the source-1 operand select.
- Consumes the selected src1 and a src2 operand, plus an op code.
- Single-cycle ALU ops produce a registered result; MUL uses a multi-cycle shift-add iteration.
- start/busy/done handshake to the control unit; result and flags are held until the next accepted operation.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, 5, iteration counter width; must satisfy 2**CNT_W >= WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; accepted only in IDLE.
- op  input  4  operation code, sampled with start.
- src1  input  WIDTH  operand 1 from the src1 select; multiplicand for MUL.
- src2  input  WIDTH  operand 2; multiplier for MUL.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse when result/flags become valid.
- result  output  WIDTH  registered result.
- flags  output  4  {N,Z,C,V}, registered.

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is asynchronous and active-high.
- Reset (async, any state, including mid-MUL): state=IDLE, busy=0, done=0, result=0, flags=0, counter=0, internal registers=0.
- State machine, IDLE:
  - start=1 with an ALU op -> DONE.
  - start=1 with op=MUL -> MUL.
  - start=0 -> stay in IDLE.
- State machine, MUL: one iteration per cycle.
  - Without the optional feature: exit to DONE after exactly WIDTH iterations.
- State machine, DONE: done=1 for exactly this cycle, then unconditionally -> IDLE.
- start while busy=1: ignored, with no effect on operands or state.
- back-to-back: start may be asserted in the IDLE cycle that immediately follows DONE.
- Op codes:
  - 0 ADD: src1+src2
  - 1 SUB: src1-src2
  - 2 AND
  - 3 ORR
  - 4 EOR
  - 5 MOV: result=src2
  - 6 MUL: low WIDTH bits of src1*src2
  - 7-15: reserved, handled like an ALU op with result=0 and flags=0.
- Latency: start accepted at edge T.
  - ALU op: done=1 and result valid in the cycle after T (edge T+1).
  - MUL: done at edge T+WIDTH+1.
- MUL datapath, loaded at accept: acc=0, mcand=src1, mplr=src2.
  - Each MUL cycle: if mplr[0] then acc += mcand.
  - Then mcand <<= 1 and mplr >>= 1; the counter increments.
  - All arithmetic is truncated to WIDTH bits.
- Flags:
  - N=result[WIDTH-1].
  - Z=(result==0).
  - ADD: C=carry out; V=signed overflow.
  - SUB: C=NOT borrow (src1>=src2 unsigned); V=signed overflow.
  - All other ops: C=0, V=0.
- result and flags update only at the transition into DONE and hold until the next accepted operation completes.
- Operands are captured at accept; later src1/src2 changes do not affect an op in flight.

Optional Feature:
- Macro: EXEC_EARLY_TERM_EN.
- Defined: MUL exits to DONE after the iteration in which the shifted mplr becomes 0, or after WIDTH iterations, whichever comes first.
  - Minimum is 1 MUL cycle (src2=0 or 1 -> done at T+2).
  - src2=5 -> 3 iterations -> done at T+4.
- Undefined: always WIDTH iterations; the logic is absent.
- Result values are identical in both builds.

Decomposition:
- Package exec_pkg holds:
  - the op_t enum (ADD..MUL, codes above);
  - the state_t enum (IDLE, MUL, DONE);
  - flag bit index constants (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0).
- One natural sub-module: exec_mul_iter, holding the acc/mcand/mplr registers and the counter.
  - Inputs: load, step.
  - Output: last.
  - The FSM, ALU and flag logic stay in exec_unit.

Test Plan:
- Reset mid-operation: MUL src1=7, src2=9; assert rst 10 cycles after accept -> busy=0, done=0, result=0, flags=0 immediately (async); next MUL 7*9 -> result=63 at T+33.
- ADD overflow: src1=0x7FFFFFFF, src2=1 -> done at T+1, result=0x80000000, flags N=1 Z=0 C=0 V=1.
- SUB equal: src1=5, src2=5 -> result=0, flags Z=1 C=1 N=0 V=0; SUB 3-5 -> result=0xFFFFFFFE, N=1, C=0.
- MUL truncation: src1=0x10000, src2=0x10000 -> result=0, Z=1, done exactly at T+33, one-cycle pulse.
- start during busy: assert start with op=ADD on every MUL cycle -> ignored; MUL 6*7 completes with result=42; a following ADD 1+2 -> result=3.
- EXEC_EARLY_TERM_EN defined: MUL 12*5 -> result=60, done at T+4; MUL 9*0 -> result=0, Z=1, done at T+2.
